operand_select_ext: RTL
=======================

# operand_select_ext

Parametrised, registered operand selector for the CPU datapath's ALU operand-B path. It picks one of `N_SRC` register-file operands or an `IMM_W`-bit immediate. The immediate is sign- or zero-extended per transaction to `DATA_W`. The selected operand passes through a valid/ready pipeline stage, so decode and execute can stall independently.

## Interface
- `DATA_W`, 16, operand width.
- `IMM_W`, 8, immediate width; legal range 1 ≤ `IMM_W` ≤ `DATA_W`.
- `N_SRC`, 4, number of register operand inputs; minimum 1.
- `SEL_W`, derived localparam = $clog2(`N_SRC`+1), selector width.
- `CLK`  in  1  clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has a transaction.
- `in_ready`  out  1  block can accept a transaction.
- `src`  in  `N_SRC`*`DATA_W`  packed operands; operand k is bits [k*`DATA_W` +: `DATA_W`].
- `imm`  in  `IMM_W`  raw immediate.
- `sel`  in  `SEL_W`  selection code:
  - 0..`N_SRC`-1 selects `src[k]`;
  - `N_SRC` selects the extended immediate;
  - any greater value is illegal.
- `sext`  in  1  1 = sign-extend `imm`, 0 = zero-extend.
- `out_valid`  out  1  output holds a transaction.
- `out_ready`  in  1  downstream accepts the output.
- `out_data`  out  `DATA_W`  selected operand.
- `out_err`  out  1  the transaction carried an illegal `sel`.

## Operation
- Accept: `in_valid` && `in_ready` at a rising edge.
- Output: `out_valid` && `out_ready` at a rising edge.
- Computed data for the selected code:
  - register operand: `src[sel]`;
  - immediate with `sext`=1: {{(`DATA_W`-`IMM_W`){`imm`[`IMM_W`-1]}}, `imm`};
  - immediate with `sext`=0: zero-padded `imm`;
  - when `IMM_W` = `DATA_W`, `imm` passes unchanged in both modes.
- Illegal `sel`: `out_data` = 0 and `out_err` = 1. The transaction is still accepted and still output; it is never dropped.
- `out_data` and `out_err` are registered. They change only when a new transaction loads into the output register.
- Holding rule: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_err` stay stable.
- Ordering: transactions leave strictly in acceptance order, with no duplication or loss.
- Inputs are sampled only on the accept edge. Later changes to `src`, `imm`, `sel` or `sext` do not affect an accepted transaction.

## Timing
- Reset (`reset_n`=0, asynchronous, takes effect immediately):
  - `out_valid`=0, `out_data`=0, `out_err`=0;
  - skid register empty;
  - `in_ready`=1 from the first edge after deassertion (combinationally 1 in the no-skid build).
- Reset asserted mid-transfer discards all held transactions. No output handshake completes during reset.
- Latency: a transaction accepted at edge t appears with `out_valid`=1 after edge t. Minimum latency is 1 cycle.
- Throughput: one transaction per cycle while `out_ready`=1.
- Simultaneous accept and output at the same edge: the new transaction replaces the departing one, and `out_valid` stays 1.
- Output register empty (`out_valid`=0): an accept loads it directly.

## Configuration
- Macro `OPERAND_SELECT_SKID_EN`, when defined:
  - a one-entry skid register sits behind the output register;
  - `in_ready` is a registered signal (skid empty), with no combinational path from `out_ready`;
  - if `out_ready`=0 while a transaction is accepted into a full output register, that transaction goes to the skid register and `in_ready` drops on the next cycle;
  - when the output drains, the skid entry moves to the output register and `in_ready` returns to 1;
  - up to two transactions are in flight.
- Macro undefined:
  - single output register;
  - `in_ready` = !`out_valid` || `out_ready` (combinational);
  - at most one transaction is in flight.
- Data, error and ordering behaviour is identical in both builds.

## Test plan
- Defaults, `src`={0x4444,0x3333,0x2222,0x1111} (k=3..0), `sel`=2, one accept -> next cycle `out_valid`=1, `out_data`=0x3333, `out_err`=0.
- `sel`=4, `imm`=0x80: with `sext`=1 -> `out_data`=0xFF80; with `sext`=0 -> `out_data`=0x0080. Also `imm`=0x7F with `sext`=1 -> 0x007F.
- `sel`=6 (illegal) -> `out_data`=0x0000, `out_err`=1; the next legal transaction clears `out_err`.
- Stream of 8 transactions with `out_ready` held 0 for 3 cycles mid-stream:
  - skid build: `in_ready` falls after two held transactions;
  - both builds: all 8 emerge in order with no duplicates and stable data during the stall.
- Continuous `in_valid`=1 and `out_ready`=1 for 16 cycles -> 16 outputs in 16 cycles after the first-cycle latency.
- `reset_n` pulsed low while `out_valid`=1 and the skid register is full -> immediately `out_valid`=0, `out_data`=0, `out_err`=0; after release, the first new accept appears after one cycle.

Source files
------------

// File: rtl/operand_select_ext.sv
// Registered ALU operand-B selector: register operand or sign/zero-extended immediate,
// behind a valid/ready output stage. Define OPERAND_SELECT_SKID_EN for a one-entry skid buffer.
module operand_select_ext #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned N_SRC  = 4,
    localparam int unsigned SEL_W = $clog2(N_SRC + 1)
) (
    input  logic                    CLK,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_SRC*DATA_W-1:0] src,
    input  logic [IMM_W-1:0]        imm,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sext,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_err
);

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] sel_data;
    logic              sel_err;

    generate
        if (IMM_W < DATA_W) begin : g_ext
            localparam int unsigned PadW = DATA_W - IMM_W;
            assign imm_ext = sext ? {{PadW{imm[IMM_W-1]}}, imm} : {{PadW{1'b0}}, imm};
        end else begin : g_noext
            assign imm_ext = imm;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        sel_err  = 1'b0;
        if (sel < SEL_W'(N_SRC)) begin
            for (int k = 0; k < N_SRC; k++) begin
                if (sel == SEL_W'(k)) begin
                    sel_data = src[k*DATA_W +: DATA_W];
                end
            end
        end else if (sel == SEL_W'(N_SRC)) begin
            sel_data = imm_ext;
        end else begin
            sel_err = 1'b1;
        end
    end

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q, out_err_d;

`ifdef OPERAND_SELECT_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_err_q, skid_err_d;
    logic              in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_err_d   = skid_err_q;
        if (skid_valid_q) begin
            // A full skid implies a full output register; drain skid into it.
            if (out_ready) begin
                out_data_d   = skid_data_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_valid && in_ready_q) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_err_d   = sel_err;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = sel_data;
                skid_err_d   = sel_err;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        if (in_valid && in_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_err_d   = sel_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule
